// File: rtl/enigma_stream_ctrl.sv
// Host-side stream controller for the enigma core: input FIFO, single-outstanding
// request FSM with a watchdog, and an output FIFO back to the host.
module enigma_stream_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             eng_valid,
  output logic [7:0]       eng_din,
  input  logic             eng_done,
  input  logic [7:0]       eng_dout,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] char_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_STORE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cur_q, cur_d;
  logic [7:0]       result_q, result_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eng_valid_q, eng_valid_d;
  logic [7:0]       eng_din_q, eng_din_d;
  logic             busy_q, busy_d;

  logic [7:0]       in_mem_q [DEPTH];
  logic [7:0]       in_mem_d [DEPTH];
  logic [AW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d;
  logic             in_ready_q, in_ready_d;

  logic [7:0]       out_mem_q [DEPTH];
  logic [7:0]       out_mem_d [DEPTH];
  logic [AW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;

  logic             in_push, in_pop, out_push, out_pop;

  assign in_push = in_valid && in_ready_q;
  assign out_pop = out_valid_q && out_ready;

  // Request sequencer: one character outstanding; output space is checked before the pop.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    result_d    = result_q;
    timer_d     = timer_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    eng_valid_d = 1'b0;
    eng_din_d   = eng_din_q;
    in_pop      = 1'b0;
    out_push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if ((in_cnt_q != '0) && (out_cnt_q != CW'(DEPTH))) begin
          in_pop = 1'b1;
          cur_d  = in_mem_q[in_rd_q];
          if ((cur_d >= 8'h41) && (cur_d <= 8'h5A)) begin
            state_d     = ST_ISSUE;
            eng_valid_d = 1'b1;
            eng_din_d   = cur_d;
          end else begin
            result_d = cur_d;
            state_d  = ST_STORE;
          end
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          result_d = eng_dout;
          state_d  = ST_STORE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STORE: begin
        out_push = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FIFO bookkeeping; out_data tracks the head that will be visible after this edge.
  always_comb begin
    in_mem_d  = in_mem_q;
    out_mem_d = out_mem_q;
    if (in_push) in_mem_d[in_wr_q] = in_data;
    if (out_push) out_mem_d[out_wr_q] = result_q;
    in_wr_d   = in_wr_q + AW'(in_push);
    in_rd_d   = in_rd_q + AW'(in_pop);
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    out_wr_d  = out_wr_q + AW'(out_push);
    out_rd_d  = out_rd_q + AW'(out_pop);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    in_ready_d  = (in_cnt_d != CW'(DEPTH));
    out_valid_d = (out_cnt_d != '0);
    if (out_push && ((out_cnt_q - CW'(out_pop)) == '0)) out_data_d = result_q;
    else                                                 out_data_d = out_mem_q[out_rd_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      result_q    <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      eng_valid_q <= 1'b0;
      eng_din_q   <= '0;
      busy_q      <= 1'b0;
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_cnt_q    <= '0;
      in_ready_q  <= 1'b1;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      result_q    <= result_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      eng_valid_q <= eng_valid_d;
      eng_din_q   <= eng_din_d;
      busy_q      <= busy_d;
      in_wr_q     <= in_wr_d;
      in_rd_q     <= in_rd_d;
      in_cnt_q    <= in_cnt_d;
      in_ready_q  <= in_ready_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage arrays carry no reset; validity lives in the pointers and counts.
  always_ff @(posedge clk) begin
    in_mem_q  <= in_mem_d;
    out_mem_q <= out_mem_d;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign eng_valid   = eng_valid_q;
  assign eng_din     = eng_din_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign char_count  = cnt_q;

endmodule
